key_event: RTL and testbench

KEY_EVENT -- requirements
Module: key_event

---
 rtl/key_event_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/key_event.sv | 134 +++++++++++++
 tb/tb_key_event.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// Shared definitions for the key event classifier: FSM state encodings,
// tick counter width and the bundle of one-cycle event strobes.
package key_event_pkg;

  localparam int CNT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } key_state_e;

  typedef struct packed {
    logic press;
    logic rel;
    logic short_evt;
    logic long_evt;
    logic rpt_evt;
  } key_evts_t;

  // Terminal count for an N-tick interval; the counter runs 0..N-1.
  function automatic logic [CNT_W-1:0] last_count(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both stages clear to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_event.sv
// Classifies a debounced key into press/release/short/long/auto-repeat pulses.
// The release strobe is named release_evt because "release" is a reserved word.
module key_event
  import key_event_pkg::*;
#(
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic clk,
  input  logic rst_,
  input  logic key_lvl,
  input  logic tick,
  output logic press,
  output logic release_evt,
  output logic short_evt,
  output logic long_evt,
  output logic rpt_evt,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_LAST = last_count(LONG_TICKS);
  localparam logic [CNT_W-1:0] RPT_LAST  = last_count(REPEAT_TICKS);
  localparam bit               RPT_EN    = (REPEAT_TICKS != 0);

  logic             k_s;
  logic             k_d;
  logic             k_rise;
  logic             k_fall;
  key_state_e       state;
  key_state_e       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  key_evts_t        evt_nxt;

  sync_2ff u_sync (
    .clk (clk),
    .rst_(rst_),
    .d   (key_lvl),
    .q   (k_s)
  );

  // Edge strobes are registered, which puts press three clocks after the
  // first sampling of a high key level.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      k_d    <= 1'b0;
      k_rise <= 1'b0;
      k_fall <= 1'b0;
    end else begin
      k_d    <= k_s;
      k_rise <= k_s & ~k_d;
      k_fall <= ~k_s & k_d;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Release is tested before tick so a coinciding threshold never fires.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    evt_nxt   = '0;
    case (state)
      ST_IDLE: begin
        if (k_rise) begin
          evt_nxt.press = 1'b1;
          cnt_nxt       = '0;
          state_nxt     = ST_PRESSED;
        end
      end
      ST_PRESSED: begin
        if (k_fall) begin
          evt_nxt.rel       = 1'b1;
          evt_nxt.short_evt = 1'b1;
          cnt_nxt           = '0;
          state_nxt         = ST_IDLE;
        end else if (tick) begin
          if (cnt == LONG_LAST) begin
            evt_nxt.long_evt = 1'b1;
            cnt_nxt          = '0;
            state_nxt        = ST_LONG;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_LONG: begin
        if (k_fall) begin
          evt_nxt.rel = 1'b1;
          cnt_nxt     = '0;
          state_nxt   = ST_IDLE;
        end else if (RPT_EN && tick) begin
          if (cnt == RPT_LAST) begin
            evt_nxt.rpt_evt = 1'b1;
            cnt_nxt         = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      press       <= 1'b0;
      release_evt <= 1'b0;
      short_evt   <= 1'b0;
      long_evt    <= 1'b0;
      rpt_evt     <= 1'b0;
      held        <= 1'b0;
    end else begin
      press       <= evt_nxt.press;
      release_evt <= evt_nxt.rel;
      short_evt   <= evt_nxt.short_evt;
      long_evt    <= evt_nxt.long_evt;
      rpt_evt     <= evt_nxt.rpt_evt;
      held        <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: two instances (repeat period 2 and repeat disabled)
// share stimulus; predicted events are queued and matched as they appear.
module tb_key_event;

  localparam logic [4:0] EV_PRESS = 5'b10000;
  localparam logic [4:0] EV_REL   = 5'b01000;
  localparam logic [4:0] EV_SHORT = 5'b00100;
  localparam logic [4:0] EV_LONG  = 5'b00010;
  localparam logic [4:0] EV_RPT   = 5'b00001;
  localparam int         NEVER    = 1 << 30;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
  } exp_t;

  typedef struct {
    string name;
    int    phase;
    int    len;
    int    exp_short;
    int    exp_long;
    int    exp_rpt_a;
  } vec_t;

  logic clk = 1'b0;
  logic rst_;
  logic key_lvl;
  logic tick;
  logic press_a, rel_a, short_a, long_a, rpt_a, held_a;
  logic press_b, rel_b, short_b, long_b, rpt_b, held_b;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_short[2] = '{0, 0};
  int   n_long[2]  = '{0, 0};
  int   n_rpt[2]   = '{0, 0};
  int   n_rel[2]   = '{0, 0};
  exp_t qa[$];
  exp_t qb[$];
  vec_t tbl[8];

  key_event #(.LONG_TICKS(4), .REPEAT_TICKS(2)) dut_a (
    .clk        (clk),
    .rst_       (rst_),
    .key_lvl    (key_lvl),
    .tick       (tick),
    .press      (press_a),
    .release_evt(rel_a),
    .short_evt  (short_a),
    .long_evt   (long_a),
    .rpt_evt    (rpt_a),
    .held       (held_a)
  );

  key_event #(.LONG_TICKS(4), .REPEAT_TICKS(0)) dut_b (
    .clk        (clk),
    .rst_       (rst_),
    .key_lvl    (key_lvl),
    .tick       (tick),
    .press      (press_b),
    .release_evt(rel_b),
    .short_evt  (short_b),
    .long_evt   (long_b),
    .rpt_evt    (rpt_b),
    .held       (held_b)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  // Matches any observed event strobe against the oldest prediction.
  task automatic checkOutput(input int d, input logic [4:0] got);
    exp_t e;
    if (got == 5'b0) return;
    checks++;
    if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
      errors++;
      $display("[TB] FAIL unexpected_event dut%0d cycle %0d: got %b, required none", d, cyc, got);
      return;
    end
    if (d == 0) e = qa.pop_front();
    else        e = qb.pop_front();
    if (e.cyc != cyc || e.ev != got) begin
      errors++;
      $display("[TB] FAIL event dut%0d: got %b at cycle %0d, required %b at cycle %0d",
               d, got, cyc, e.ev, e.cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    if (short_a) n_short[0]++;
    if (short_b) n_short[1]++;
    if (long_a)  n_long[0]++;
    if (long_b)  n_long[1]++;
    if (rpt_a)   n_rpt[0]++;
    if (rpt_b)   n_rpt[1]++;
    if (rel_a)   n_rel[0]++;
    if (rel_b)   n_rel[1]++;
    checkOutput(0, {press_a, rel_a, short_a, long_a, rpt_a});
    checkOutput(1, {press_b, rel_b, short_b, long_b, rpt_b});
  end

  // Called at a falling edge; the values land on posedge number cyc+1.
  task automatic applyStimulus(input logic k, input logic r);
    rst_    = r;
    key_lvl = k;
    tick    = ((cyc + 1) % 10 == 0);
    @(negedge clk);
  endtask

  task automatic pushEv(input int d, input int c, input logic [4:0] ev, input int cut);
    exp_t e;
    if (c >= cut) return;
    e.cyc = c;
    e.ev  = ev;
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  // Key sampled high on posedges p0..r0-1; events seen by the FSM 3 clocks on.
  task automatic pushModel(input int p0, input int r0, input int cut);
    for (int d = 0; d < 2; d++) begin
      int rp;
      int n;
      int m;
      bit lng;
      rp  = (d == 0) ? 2 : 0;
      n   = 0;
      m   = 0;
      lng = 1'b0;
      pushEv(d, p0 + 3, EV_PRESS, cut);
      for (int p = p0 + 4; p < r0 + 3; p++) begin
        if (p % 10 == 0) begin
          if (!lng) begin
            n++;
            if (n == 4) begin
              lng = 1'b1;
              pushEv(d, p, EV_LONG, cut);
            end
          end else if (rp != 0) begin
            m++;
            if (m == rp) begin
              m = 0;
              pushEv(d, p, EV_RPT, cut);
            end
          end
        end
      end
      pushEv(d, r0 + 3, lng ? EV_REL : (EV_REL | EV_SHORT), cut);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkEq({tag, "_a"}, int'({press_a, rel_a, short_a, long_a, rpt_a, held_a}), 0);
    checkEq({tag, "_b"}, int'({press_b, rel_b, short_b, long_b, rpt_b, held_b}), 0);
  endtask

  task automatic checkDrained(input string tag);
    checkEq({tag, "_pending_a"}, qa.size(), 0);
    checkEq({tag, "_pending_b"}, qb.size(), 0);
    checkEq({tag, "_held_a"}, int'(held_a), 0);
    checkEq({tag, "_held_b"}, int'(held_b), 0);
  endtask

  task automatic runVector(input vec_t v);
    int p0;
    int s_short[2];
    int s_long[2];
    int s_rpt[2];
    s_short = n_short;
    s_long  = n_long;
    s_rpt   = n_rpt;
    while ((cyc + 1) % 10 != v.phase) applyStimulus(1'b0, 1'b1);
    p0 = cyc + 1;
    pushModel(p0, p0 + v.len, NEVER);
    for (int i = 0; i < v.len; i++) begin
      if (i == v.len - 1 && v.len >= 5) begin
        checkEq({v.name, "_held_mid_a"}, int'(held_a), 1);
        checkEq({v.name, "_held_mid_b"}, int'(held_b), 1);
      end
      applyStimulus(1'b1, 1'b1);
    end
    repeat (30) applyStimulus(1'b0, 1'b1);
    checkDrained(v.name);
    checkEq({v.name, "_short_a"}, n_short[0] - s_short[0], v.exp_short);
    checkEq({v.name, "_short_b"}, n_short[1] - s_short[1], v.exp_short);
    checkEq({v.name, "_long_a"}, n_long[0] - s_long[0], v.exp_long);
    checkEq({v.name, "_long_b"}, n_long[1] - s_long[1], v.exp_long);
    checkEq({v.name, "_rpt_a"}, n_rpt[0] - s_rpt[0], v.exp_rpt_a);
    checkEq({v.name, "_rpt_b"}, n_rpt[1] - s_rpt[1], 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p0;
    int x0;
    int s_rel;

    tbl[0] = '{"short",         1, 25,  1, 0, 0};
    tbl[1] = '{"long",          1, 100, 0, 1, 3};
    tbl[2] = '{"race",          1, 36,  1, 0, 0};
    tbl[3] = '{"race_plus1",    1, 37,  0, 1, 0};
    tbl[4] = '{"race_minus1",   1, 35,  1, 0, 0};
    tbl[5] = '{"rel_on_rpt",    7, 60,  0, 1, 0};
    tbl[6] = '{"tick_at_entry", 6, 52,  0, 1, 1};
    tbl[7] = '{"one_clk",       0, 1,   1, 0, 0};

    rst_    = 1'b0;
    key_lvl = 1'b0;
    tick    = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0);
    checkQuiet("reset");

    $display("[TB] idle with ticks running");
    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b0, 1'b1);
      if (i % 20 == 19) checkQuiet("idle");
    end

    foreach (tbl[i]) begin
      $display("[TB] vector %s", tbl[i].name);
      runVector(tbl[i]);
    end

    $display("[TB] back-to-back short presses");
    while ((cyc + 1) % 10 != 1) applyStimulus(1'b0, 1'b1);
    p0 = cyc + 1;
    pushModel(p0, p0 + 8, NEVER);
    pushModel(p0 + 12, p0 + 20, NEVER);
    repeat (8) applyStimulus(1'b1, 1'b1);
    repeat (4) applyStimulus(1'b0, 1'b1);
    repeat (8) applyStimulus(1'b1, 1'b1);
    repeat (30) applyStimulus(1'b0, 1'b1);
    checkDrained("b2b");

    $display("[TB] reset during long hold");
    s_rel = n_rel[0];
    while ((cyc + 1) % 10 != 1) applyStimulus(1'b0, 1'b1);
    p0 = cyc + 1;
    pushModel(p0, p0 + 60, p0 + 49);
    repeat (49) applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkQuiet("in_reset");
    end
    x0 = cyc + 1;
    pushModel(x0, x0 + 70, NEVER);
    repeat (70) applyStimulus(1'b1, 1'b1);
    repeat (30) applyStimulus(1'b0, 1'b1);
    checkDrained("post_reset");
    checkEq("post_reset_release_count", n_rel[0] - s_rel, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
